// File: rtl/sync_fifo_thresh_if.sv
// Bus bundle for sync_fifo_thresh: write/read handshakes, status flags and error control.
interface sync_fifo_thresh_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             W_INC;
    logic [WIDTH-1:0] WR_DATA;
    logic             R_INC;
    logic             CLR_ERR;
    logic [WIDTH-1:0] RD_DATA;
    logic             RD_VALID;
    logic             FULL;
    logic             EMPTY;
    logic             ALMOST_FULL;
    logic             ALMOST_EMPTY;
    logic [CW-1:0]    COUNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    modport master (
        output W_INC, WR_DATA, R_INC, CLR_ERR,
        input  RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );

    modport slave (
        input  W_INC, WR_DATA, R_INC, CLR_ERR,
        output RD_DATA, RD_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY,
               COUNT, OVERFLOW, UNDERFLOW
    );
endinterface

// File: rtl/sync_fifo_thresh.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, sticky
// overflow/underflow flags and a selectable registered or fall-through read port.
module sync_fifo_thresh #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4,
    parameter int FWFT     = 0
) (
    input logic             CLK,
    input logic             RST,
    sync_fifo_thresh_if.slave fifo
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic             full;
    logic             empty;
    logic             wr_acc;
    logic             rd_acc;
    logic             overflow;
    logic             underflow;

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign wr_acc = fifo.W_INC & ~full;
    assign rd_acc = fifo.R_INC & ~empty;

    always_ff @(posedge CLK) begin
        if (wr_acc)
            mem[wptr] <= fifo.WR_DATA;
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_acc)
                wptr <= wptr + AW'(1);
            if (rd_acc)
                rptr <= rptr + AW'(1);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A fresh error in the same cycle as CLR_ERR keeps the flag set.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (fifo.W_INC && full)
                overflow <= 1'b1;
            else if (fifo.CLR_ERR)
                overflow <= 1'b0;
            if (fifo.R_INC && empty)
                underflow <= 1'b1;
            else if (fifo.CLR_ERR)
                underflow <= 1'b0;
        end
    end

    assign fifo.FULL         = full;
    assign fifo.EMPTY        = empty;
    assign fifo.ALMOST_FULL  = (count >= CW'(AF_LEVEL));
    assign fifo.ALMOST_EMPTY = (count <= CW'(AE_LEVEL));
    assign fifo.COUNT        = count;
    assign fifo.OVERFLOW     = overflow;
    assign fifo.UNDERFLOW    = underflow;

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is masked while empty so stale memory never reaches the port.
            assign fifo.RD_DATA  = empty ? '0 : mem[rptr];
            assign fifo.RD_VALID = ~empty;
        end else begin : g_reg
            logic [WIDTH-1:0] rd_data;
            logic             rd_valid;

            always_ff @(posedge CLK or negedge RST) begin
                if (!RST) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
                end else begin
                    rd_valid <= rd_acc;
                    if (rd_acc)
                        rd_data <= mem[rptr];
                end
            end

            assign fifo.RD_DATA  = rd_data;
            assign fifo.RD_VALID = rd_valid;
        end
    endgenerate
endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Self-checking bench: registered-read and FWFT instances share stimulus and a queue-based reference model.
module tb_sync_fifo_thresh;
    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_thresh_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) f0 ();
    sync_fifo_thresh_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) f1 ();

    sync_fifo_thresh #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0))
        dut_reg (.CLK(clk), .RST(rst), .fifo(f0.slave));
    sync_fifo_thresh #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1))
        dut_fwft (.CLK(clk), .RST(rst), .fifo(f1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] q [$];
    bit               m_of;
    bit               m_uf;
    bit               m_rv;
    logic [WIDTH-1:0] m_rd;

    typedef struct {
        bit               w;
        bit               r;
        bit               clr;
        logic [WIDTH-1:0] d;
        int               e_count;
        bit               e_valid;
        logic [WIDTH-1:0] e_data;
        bit               e_uf;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit clr);
        f0.W_INC = w; f0.WR_DATA = d; f0.R_INC = r; f0.CLR_ERR = clr;
        f1.W_INC = w; f1.WR_DATA = d; f1.R_INC = r; f1.CLR_ERR = clr;
    endtask

    task automatic model_reset();
        q.delete();
        m_of = 0; m_uf = 0; m_rv = 0; m_rd = '0;
    endtask

    task automatic model_edge(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit clr);
        bit full_p, empty_p, wa, ra;
        full_p  = (q.size() == DEPTH);
        empty_p = (q.size() == 0);
        wa = w && !full_p;
        ra = r && !empty_p;
        m_rv = ra;
        if (ra) m_rd = q.pop_front();
        if (wa) q.push_back(d);
        if (w && full_p) m_of = 1; else if (clr) m_of = 0;
        if (r && empty_p) m_uf = 1; else if (clr) m_uf = 0;
    endtask

    task automatic check_model();
        int n;
        n = q.size();
        chk("count",        32'(f0.COUNT),        32'(n));
        chk("full",         32'(f0.FULL),         32'(n == DEPTH));
        chk("empty",        32'(f0.EMPTY),        32'(n == 0));
        chk("almost_full",  32'(f0.ALMOST_FULL),  32'(n >= AF));
        chk("almost_empty", 32'(f0.ALMOST_EMPTY), 32'(n <= AE));
        chk("overflow",     32'(f0.OVERFLOW),     32'(m_of));
        chk("underflow",    32'(f0.UNDERFLOW),    32'(m_uf));
        chk("rd_valid",     32'(f0.RD_VALID),     32'(m_rv));
        chk("rd_data",      32'(f0.RD_DATA),      32'(m_rd));
        chk("fwft_count",   32'(f1.COUNT),        32'(n));
        chk("fwft_valid",   32'(f1.RD_VALID),     32'(n != 0));
        if (n != 0)
            chk("fwft_data", 32'(f1.RD_DATA), 32'(q[0]));
    endtask

    task automatic step(input bit w, input logic [WIDTH-1:0] d, input bit r, input bit clr);
        drive(w, d, r, clr);
        @(posedge clk);
        model_edge(w, d, r, clr);
        #1;
        check_model();
    endtask

    // Asynchronous reset asserted mid-cycle with a write request held high.
    task automatic do_reset();
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        model_reset();
        check_model();
        repeat (3) @(posedge clk);
        #1;
        check_model();
        chk("reset_count", 32'(f0.COUNT), 32'd0);
        chk("reset_empty", 32'(f0.EMPTY), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        tbl[0] = '{w:1, r:0, clr:0, d:8'h11, e_count:1, e_valid:0, e_data:8'h00, e_uf:0};
        tbl[1] = '{w:1, r:0, clr:0, d:8'h22, e_count:2, e_valid:0, e_data:8'h00, e_uf:0};
        tbl[2] = '{w:0, r:1, clr:0, d:8'h00, e_count:1, e_valid:1, e_data:8'h11, e_uf:0};
        tbl[3] = '{w:1, r:1, clr:0, d:8'h33, e_count:1, e_valid:1, e_data:8'h22, e_uf:0};
        tbl[4] = '{w:0, r:1, clr:0, d:8'h00, e_count:0, e_valid:1, e_data:8'h33, e_uf:0};
        tbl[5] = '{w:0, r:1, clr:0, d:8'h00, e_count:0, e_valid:0, e_data:8'h33, e_uf:1};
        tbl[6] = '{w:0, r:0, clr:1, d:8'h00, e_count:0, e_valid:0, e_data:8'h33, e_uf:0};
        tbl[7] = '{w:1, r:1, clr:0, d:8'h44, e_count:1, e_valid:0, e_data:8'h33, e_uf:1};
        tbl[8] = '{w:0, r:1, clr:1, d:8'h00, e_count:0, e_valid:1, e_data:8'h44, e_uf:0};

        rst = 1'b0;
        drive(1'b1, 8'hEE, 1'b0, 1'b0);
        model_reset();
        #12;
        do_reset();

        foreach (tbl[i]) begin
            step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].clr);
            chk("tbl_count", 32'(f0.COUNT),     32'(tbl[i].e_count));
            chk("tbl_valid", 32'(f0.RD_VALID),  32'(tbl[i].e_valid));
            chk("tbl_data",  32'(f0.RD_DATA),   32'(tbl[i].e_data));
            chk("tbl_uf",    32'(f0.UNDERFLOW), 32'(tbl[i].e_uf));
        end

        // Fill and drain with known data.
        do_reset();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 8'(i), 1'b0, 1'b0);
            chk("fill_af", 32'(f0.ALMOST_FULL), 32'(i >= AF));
        end
        chk("fill_full",  32'(f0.FULL),  32'd1);
        chk("fill_count", 32'(f0.COUNT), 32'd16);
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("drain_valid", 32'(f0.RD_VALID), 32'd1);
            chk("drain_data",  32'(f0.RD_DATA),  32'(i));
        end
        chk("drain_empty", 32'(f0.EMPTY), 32'd1);

        // Pointer wrap: two rounds of ten.
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 10; i++) begin
                step(1'b1, 8'(8'h80 + 16 * k + i), 1'b0, 1'b0);
                chk("wrap_count_max", 32'(f0.COUNT <= 10), 32'd1);
            end
            for (int i = 0; i < 10; i++) begin
                step(1'b0, '0, 1'b1, 1'b0);
                chk("wrap_data", 32'(f0.RD_DATA), 32'(8'h80 + 16 * k + i));
            end
        end

        // Simultaneous read/write at steady occupancy, then at empty.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 8'(8'hD0 + i), 1'b1, 1'b0);
            chk("simul_count", 32'(f0.COUNT), 32'd5);
        end
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, 1'b0);
        step(1'b1, 8'h77, 1'b1, 1'b0);
        chk("simul_empty_count", 32'(f0.COUNT),     32'd1);
        chk("simul_empty_uf",    32'(f0.UNDERFLOW), 32'd1);
        step(1'b0, '0, 1'b1, 1'b1);

        // Overflow handling and clear priority.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("ovf_set",   32'(f0.OVERFLOW), 32'd1);
        chk("ovf_count", 32'(f0.COUNT),    32'd16);
        step(1'b1, 8'hBB, 1'b0, 1'b1);
        chk("ovf_clr_conflict", 32'(f0.OVERFLOW), 32'd1);
        step(1'b0, '0, 1'b0, 1'b1);
        chk("ovf_clr", 32'(f0.OVERFLOW), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b0, '0, 1'b1, 1'b0);
            chk("ovf_drain_data", 32'(f0.RD_DATA), 32'(8'h30 + i));
        end

        // Fall-through visibility and pop.
        step(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("fwft_vis_valid", 32'(f1.RD_VALID), 32'd1);
        chk("fwft_vis_data",  32'(f1.RD_DATA),  32'h5A);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("fwft_pop_empty", 32'(f1.EMPTY),    32'd1);
        chk("fwft_pop_valid", 32'(f1.RD_VALID), 32'd0);

        // Reset in the middle of traffic.
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        do_reset();

        // Randomised traffic with phases biased toward filling and draining.
        for (int i = 0; i < 3000; i++) begin
            int pw, pr;
            case ((i / 150) % 4)
                0:       begin pw = 80; pr = 20; end
                1:       begin pw = 50; pr = 50; end
                2:       begin pw = 20; pr = 80; end
                default: begin pw = 90; pr = 90; end
            endcase
            step($urandom_range(99) < pw, 8'($urandom), $urandom_range(99) < pr,
                 $urandom_range(99) < 3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
